// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared types and constants for the UART SHA-256 controller:
//               controller state encoding, block/digest geometry, ASCII
//               line-terminator codes and a nibble-to-hex-character helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int MAX_MSG_BYTES = 55;
  localparam int MSG_W         = 8 * MAX_MSG_BYTES;  // 440-bit message word
  localparam int BLOCK_W       = 512;
  localparam int DIGEST_W      = 256;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAD       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_TX   = 3'd5
  } state_e;

  // 0..9 -> '0'..'9', 10..15 -> 'a'..'f' (0x57 + 10 = 0x61 = 'a')
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_ctrl_if
// Description : Bundle of the controller's message, core and UART-TX signals.
//               master : controller view (drives core_start/core_block,
//                        tx_dv/tx_byte, busy, overrun_cnt)
//               slave  : environment view (sipo, core, UART TX)
// Parameters  : OVR_W - width of the overrun counter
// Revision    : 1.0 - initial release
// ============================================================================
interface sha256_ctrl_if
  import sha256_pkg::*;
#(
  parameter int OVR_W = 8
) ();

  logic                  msg_valid;
  logic [5:0]            byte_valid;
  logic [MSG_W-1:0]      msg_word;
  logic                  core_ready;
  logic                  core_start;
  logic [BLOCK_W-1:0]    core_block;
  logic                  core_done;
  logic [DIGEST_W-1:0]   core_digest;
  logic                  tx_active;
  logic                  tx_done;
  logic                  tx_dv;
  logic [7:0]            tx_byte;
  logic                  busy;
  logic [OVR_W-1:0]      overrun_cnt;

  modport master (
    input  msg_valid, byte_valid, msg_word,
    input  core_ready, core_done, core_digest,
    input  tx_active, tx_done,
    output core_start, core_block, tx_dv, tx_byte, busy, overrun_cnt
  );

  modport slave (
    output msg_valid, byte_valid, msg_word,
    output core_ready, core_done, core_digest,
    output tx_active, tx_done,
    input  core_start, core_block, tx_dv, tx_byte, busy, overrun_cnt
  );

endinterface
`default_nettype wire

// File: rtl/sha256_ctrl_pad.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pad
// Description : Combinational single-block SHA-256 padding.
//               i_msg   - message, byte i at [439-8i -: 8]
//               i_len   - length in bytes, 0..55 (already clamped)
//               o_block - message bytes, 0x80 marker, zeros, 64-bit bit length
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_pad
  import sha256_pkg::*;
(
  input  wire logic [MSG_W-1:0]   i_msg,
  input  wire logic [5:0]         i_len,
  output logic      [BLOCK_W-1:0] o_block
);

  // Bytes at or beyond the length are never taken from the message, so stale
  // data left in the sipo word cannot leak into the block.
  for (genvar i = 0; i < MAX_MSG_BYTES; i++) begin : g_byte
    assign o_block[BLOCK_W-1-8*i -: 8] =
        (i_len > 6'(i))  ? i_msg[MSG_W-1-8*i -: 8] :
        (i_len == 6'(i)) ? 8'h80 : 8'h00;
  end

  // Byte 55 can only ever hold the end marker (a 55-byte message).
  assign o_block[BLOCK_W-1-8*MAX_MSG_BYTES -: 8] = (i_len == 6'd55) ? 8'h80 : 8'h00;

  // Big-endian bit length = 8 * bytes.
  assign o_block[63:0] = {55'd0, i_len, 3'b000};

endmodule
`default_nettype wire

// File: rtl/sha256_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_ctrl
// Description : Sequencer between the sipo byte collector, the SHA-256 core
//               and the UART transmitter. Pads one message into a block,
//               runs the core, then streams the digest out over UART TX.
//               Counts messages dropped while busy (saturating).
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               bus   - sha256_ctrl_if.master (message, core, TX, status)
// Parameters  : OVR_W - overrun counter width
// Macros      : SHA256_CTRL_HEX_EN - send the digest as lowercase ASCII hex
//               plus CR LF (66 bytes) instead of 32 raw bytes
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter int OVR_W = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  sha256_ctrl_if.master  bus
);

`ifdef SHA256_CTRL_HEX_EN
  localparam logic [6:0] LAST_IDX = 7'd65;
  localparam int         SHIFT    = 4;
`else
  localparam logic [6:0] LAST_IDX = 7'd31;
  localparam int         SHIFT    = 8;
`endif

  state_e              state_q, state_d;
  logic [5:0]          len_q, len_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic [DIGEST_W-1:0] dig_q, dig_d;
  logic [6:0]          idx_q, idx_d;
  logic                core_start_q, core_start_d;
  logic                tx_dv_q, tx_dv_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                busy_q, busy_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;

  logic [BLOCK_W-1:0]  w_pad_block;
  logic [7:0]          w_tx_char;

  sha256_pad u_pad (
    .i_msg   (msg_q),
    .i_len   (len_q),
    .o_block (w_pad_block)
  );

  // Character for the current index; the digest register is shifted left
  // after every sent character so its top bits are always the next payload.
  always_comb begin
`ifdef SHA256_CTRL_HEX_EN
    if (idx_q == 7'd64)      w_tx_char = ASCII_CR;
    else if (idx_q == 7'd65) w_tx_char = ASCII_LF;
    else                     w_tx_char = nib2hex(dig_q[DIGEST_W-1 -: 4]);
`else
    w_tx_char = dig_q[DIGEST_W-1 -: 8];
`endif
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    msg_d        = msg_q;
    block_d      = block_q;
    dig_d        = dig_q;
    idx_d        = idx_q;
    core_start_d = 1'b0;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    ovr_d        = ovr_q;

    if (bus.msg_valid && (state_q != ST_IDLE) && (ovr_q != {OVR_W{1'b1}}))
      ovr_d = ovr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.msg_valid) begin
          msg_d   = bus.msg_word;
          len_d   = (bus.byte_valid > 6'd55) ? 6'd55 : bus.byte_valid;
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        block_d = w_pad_block;
        state_d = ST_START;
      end
      ST_START: begin
        if (bus.core_ready) begin
          core_start_d = 1'b1;
          state_d      = ST_WAIT_CORE;
        end
      end
      ST_WAIT_CORE: begin
        if (bus.core_done) begin
          dig_d   = bus.core_digest;
          idx_d   = 7'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = w_tx_char;
          state_d   = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (bus.tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 7'd1;
            dig_d   = dig_q << SHIFT;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      msg_q        <= '0;
      block_q      <= '0;
      dig_q        <= '0;
      idx_q        <= '0;
      core_start_q <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      msg_q        <= msg_d;
      block_q      <= block_d;
      dig_q        <= dig_d;
      idx_q        <= idx_d;
      core_start_q <= core_start_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.core_start  = core_start_q;
  assign bus.core_block  = block_q;
  assign bus.tx_dv       = tx_dv_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.busy        = busy_q;
  assign bus.overrun_cnt = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_ctrl
// Description : Directed self-checking bench for sha256_ctrl with a simple
//               core model (returns a preset digest after a set latency) and
//               a UART TX model (busy for a few cycles per byte).
// Macros      : SHA256_CTRL_HEX_EN - expects the ASCII hex output format
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_ctrl;

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_55A   = 256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_ctrl_if #(.OVR_W(8)) bus ();

  sha256_ctrl #(.OVR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- core model ----------------
  logic [255:0] model_digest;
  int           core_lat    = 4;
  int           core_cnt;
  bit           core_busy;
  logic [511:0] blk_at_start;
  int           core_starts = 0;
  int           blk_changed = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      core_busy       = 1'b0;
      core_cnt        = 0;
      bus.core_done   = 1'b0;
      bus.core_ready  = 1'b1;
      bus.core_digest = '0;
    end else begin
      bus.core_done = 1'b0;
      if (core_busy) begin
        if (bus.core_block !== blk_at_start) blk_changed++;
        if (core_cnt == 0) begin
          bus.core_done   = 1'b1;
          bus.core_digest = model_digest;
          core_busy       = 1'b0;
        end else begin
          core_cnt--;
        end
      end else if (bus.core_start) begin
        blk_at_start = bus.core_block;
        core_busy    = 1'b1;
        core_cnt     = core_lat;
        core_starts++;
      end
      bus.core_ready = !core_busy;
    end
  end

  // ---------------- UART TX model ----------------
  logic [7:0] txq[$];
  int         tx_cnt;
  int         tx_dones = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_active = 1'b0;
      bus.tx_done   = 1'b0;
      tx_cnt        = 0;
    end else begin
      bus.tx_done = 1'b0;
      if (bus.tx_dv) begin
        txq.push_back(bus.tx_byte);
        bus.tx_active = 1'b1;
        tx_cnt        = 3;
      end else if (bus.tx_active) begin
        if (tx_cnt == 0) begin
          bus.tx_active = 1'b0;
          bus.tx_done   = 1'b1;
          tx_dones++;
        end else begin
          tx_cnt--;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] hexc(input logic [3:0] n);
    case (n)
      4'h0: return 8'h30; 4'h1: return 8'h31; 4'h2: return 8'h32; 4'h3: return 8'h33;
      4'h4: return 8'h34; 4'h5: return 8'h35; 4'h6: return 8'h36; 4'h7: return 8'h37;
      4'h8: return 8'h38; 4'h9: return 8'h39; 4'ha: return 8'h61; 4'hb: return 8'h62;
      4'hc: return 8'h63; 4'hd: return 8'h64; 4'he: return 8'h65; default: return 8'h66;
    endcase
  endfunction

  task automatic send_msg(input logic [5:0] len, input logic [439:0] w);
    bus.byte_valid = len;
    bus.msg_word   = w;
    bus.msg_valid  = 1'b1;
    @(negedge clk);
    bus.msg_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle-timeout"}, {511'd0, bus.busy}, 512'd0);
  endtask

  task automatic wait_core_start(input string tag);
    int n = 0;
    while (!bus.core_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " core_start-timeout"}, {511'd0, bus.core_start}, 512'd1);
  endtask

  // Compare the captured TX stream against the digest that the core returned.
  task automatic check_stream(input string tag, input logic [255:0] dig);
    logic [255:0] got;
    got = '0;
`ifdef SHA256_CTRL_HEX_EN
    check({tag, " tx count"}, 512'(txq.size()), 512'd66);
    if (txq.size() == 66) begin
      for (int i = 0; i < 32; i++) begin
        check({tag, " hex hi"}, {504'd0, txq[2*i]},   {504'd0, hexc(dig[255-8*i -: 4])});
        check({tag, " hex lo"}, {504'd0, txq[2*i+1]}, {504'd0, hexc(dig[251-8*i -: 4])});
      end
      check({tag, " cr lf"}, {496'd0, txq[64], txq[65]}, {496'd0, 16'h0D0A});
    end
`else
    check({tag, " tx count"}, 512'(txq.size()), 512'd32);
    for (int i = 0; i < txq.size() && i < 32; i++) got = {got[247:0], txq[i]};
    check({tag, " digest"}, {256'd0, got}, {256'd0, dig});
`endif
  endtask

  // Full message: busy rises, block appears two cycles after msg_valid,
  // the digest streams out and the block stays stable while the core runs.
  task automatic run_msg(input string tag, input logic [5:0] len, input logic [439:0] w,
                         input logic [511:0] exp_block, input logic [255:0] dig);
    int starts0;
    starts0      = core_starts;
    model_digest = dig;
    txq.delete();
    send_msg(len, w);
    check({tag, " busy"}, {511'd0, bus.busy}, 512'd1);
    @(negedge clk);
    check({tag, " block"}, bus.core_block, exp_block);
    wait_idle(tag);
    check({tag, " one core run"}, 512'(core_starts - starts0), 512'd1);
    check_stream(tag, dig);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;
    bus.msg_valid  = 1'b0;
    bus.byte_valid = '0;
    bus.msg_word   = '0;
    model_digest   = '0;

    repeat (3) @(negedge clk);
    check("reset block", bus.core_block, 512'd0);
    check("reset misc", {492'd0, bus.busy, bus.core_start, bus.tx_dv, bus.tx_byte, bus.overrun_cnt}, 512'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after reset", {511'd0, bus.busy}, 512'd0);

    // "abc"
    run_msg("abc", 6'd3, {24'h616263, 416'd0}, {32'h61626380, 416'd0, 64'h18}, DIG_ABC);
`ifdef SHA256_CTRL_HEX_EN
    if (txq.size() == 66)
      check("abc hex first", {496'd0, txq[0], txq[1]}, {496'd0, 16'h6261});
`else
    if (txq.size() == 32)
      check("abc first four", {480'd0, txq[0], txq[1], txq[2], txq[3]}, {480'd0, 32'hba7816bf});
`endif

    // empty message
    run_msg("empty", 6'd0, {440{1'b1}}, {8'h80, 440'd0, 64'd0}, DIG_EMPTY);

    // 55 x 'A'
    run_msg("len55", 6'd55, {55{8'h41}}, {{55{8'h41}}, 8'h80, 64'h1B8}, DIG_55A);

    // length 63 clamps to 55
    run_msg("len63", 6'd63, {55{8'h41}}, {{55{8'h41}}, 8'h80, 64'h1B8}, DIG_55A);

    // garbage past the length is masked
    run_msg("mask", 6'd3, {24'h616263, {52{8'hFF}}}, {32'h61626380, 416'd0, 64'h18}, DIG_ABC);

    check("no overrun yet", {504'd0, bus.overrun_cnt}, 512'd0);
    check("block stable during core", 512'(blk_changed), 512'd0);

    // overrun during WAIT_CORE
    core_lat     = 20;
    model_digest = DIG_ABC;
    txq.delete();
    base = core_starts;
    send_msg(6'd3, {24'h616263, 416'd0});
    wait_core_start("ovr");
    send_msg(6'd0, '0);
    check("ovr count 1", {504'd0, bus.overrun_cnt}, 512'd1);
    wait_idle("ovr");
    check("ovr single core run", 512'(core_starts - base), 512'd1);
    check_stream("ovr", DIG_ABC);

    // saturation: 260 more drops while the core is slow
    core_lat     = 400;
    model_digest = DIG_ABC;
    txq.delete();
    send_msg(6'd3, {24'h616263, 416'd0});
    wait_core_start("sat");
    bus.msg_valid = 1'b1;
    repeat (100) @(negedge clk);
    check("ovr count 101", {504'd0, bus.overrun_cnt}, 512'd101);
    repeat (160) @(negedge clk);
    bus.msg_valid = 1'b0;
    check("ovr saturated", {504'd0, bus.overrun_cnt}, 512'd255);
    wait_idle("sat");
    check("ovr stays saturated", {504'd0, bus.overrun_cnt}, 512'd255);

    // reset after the 10th tx_done
    core_lat     = 4;
    model_digest = DIG_ABC;
    txq.delete();
    base = tx_dones;
    send_msg(6'd3, {24'h616263, 416'd0});
    n = 0;
    while (tx_dones < base + 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tenth tx_done reached", 512'(tx_dones - base), 512'd10);
    rst_n = 1'b0;
    #1;
    check("midrun reset block", bus.core_block, 512'd0);
    check("midrun reset misc", {492'd0, bus.busy, bus.core_start, bus.tx_dv, bus.tx_byte, bus.overrun_cnt}, 512'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no resume after reset", {511'd0, bus.busy}, 512'd0);

    run_msg("abc2", 6'd3, {24'h616263, 416'd0}, {32'h61626380, 416'd0, 64'h18}, DIG_ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
